bf_jump_table_builder: RTL and testbench
========================================

# bf_jump_table_builder

Pre-run scanner that walks program memory once, matches `[`/`]` pairs with a hardware stack, and fills a jump table RAM so the main controller can take loop branches in one cycle instead of bracket-counting PC walks. It sits between program memory (shared read port, owned by this block while `busy`) and the jump-table RAM write port. It is started by the top level after program load and before the controller leaves `start`.

## Interface
- `PC_W`, 8: program / jump-table address width (depth 2^PC_W).
- `STK_DEPTH`, 16: bracket stack entries (max nesting).
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  pulse; begins scan from address 0.
- `prog_addr`  out  PC_W  program memory read address.
- `prog_data`  in  4  opcode at `prog_addr`, valid one cycle after address (synchronous RAM).
- `jt_we`  out  1  jump-table write enable.
- `jt_addr`  out  PC_W  jump-table write address.
- `jt_data`  out  PC_W  matching bracket address.
- `busy`  out  1  scan in progress; controller must not start.
- `done`  out  1  level; scan finished with no error.
- `error`  out  1  level; scan aborted.
- `err_code`  out  2  0 none, 1 unmatched `]`, 2 unmatched `[`, 3 nesting overflow.

## Operation
- Opcodes (4-bit): `<`=0, `>`=1, `+`=2, `-`=3, `[`=4, `]`=5, `.`=6, `,`=7, stop=F; all others are ignored (treated as no-op).
- States: IDLE, ISSUE, EVAL, WR_OPEN, WR_CLOSE, FIN, ERR.
- IDLE/FIN/ERR: `start` -> clear `done`/`error`/`err_code`, clear stack, pc=0, go ISSUE.
- ISSUE: drive `prog_addr`=pc; go EVAL.
- EVAL (`prog_data` valid):
  - `[`: stack full -> ERR code 3; else push pc.
  - `]`: stack empty -> ERR code 1; else pop into `open`, go WR_OPEN.
  - stop: stack non-empty -> ERR code 2; else FIN.
  - other: no action.
  - Non-terminal cases advance: pc == 2^PC_W-1 -> end of program, same check as stop; else pc+1, ISSUE.
- WR_OPEN: `jt_we`=1, `jt_addr`=`open`, `jt_data`=pc.
- WR_CLOSE: `jt_we`=1, `jt_addr`=pc, `jt_data`=`open`; then advance as in EVAL.
- `busy`=1 in ISSUE..WR_CLOSE. `done`=1 in FIN; `error`=1 and `err_code` held in ERR; both held until next `start` or reset.
- Non-bracket jump-table entries are not written (contents undefined; controller only reads at bracket addresses).

## Timing
- Reset: state IDLE; `busy`, `done`, `error`, `jt_we` = 0; `err_code`, `prog_addr`, `jt_addr`, `jt_data` = 0; stack empty.
- `start` sampled high in IDLE -> `busy` high next cycle.
- Cost per opcode: 2 cycles (ISSUE+EVAL); `]` costs 4 (two writes, consecutive cycles, `open` entry first).
- FIN/ERR entered on the cycle after the terminating EVAL; `busy` falls the same edge.
- `start` while `busy`: ignored. `start` in FIN/ERR: restart, flags clear on the same edge.
- Reset mid-scan: returns to IDLE on the next edge; no further `jt_we`; partially written table is invalid.
- pc wrap never occurs: last address terminates the scan.

## Structure
- Shared package `bf_pkg`: opcode constants (already used by control), `err_code` constants, `PC_W` default.
- Sub-module `bf_bracket_stack`: LIFO of `STK_DEPTH` x `PC_W`, push/pop/empty/full, synchronous clear; pop data combinational from top.

## Test plan
- Program `+[->+<]F` -> writes jt[1]=6 then jt[6]=1; `done` after 2*7+2+2=18 cycles + FIN; `error`=0.
- Nested `[[]]F` -> writes (1,2),(2,1),(0,3),(3,0) in that order; `done`.
- `]F` -> ERR, `err_code`=1, no `jt_we` pulse ever.
- `[[F` -> ERR `err_code`=2; `[`x17 with STK_DEPTH=16 -> ERR `err_code`=3 at address 16.
- No stop opcode, 256 `+` -> scan ends at address 255, `done`=1.
- Reset asserted during WR_OPEN -> next cycle IDLE, `jt_we`=0, `busy`=0; subsequent `start` rescans correctly.

Source files
------------

// File: rtl/bf_pkg.sv
// Shared opcode, error-code and scanner-state definitions for the bf core.
package bf_pkg;

    localparam int unsigned PC_W_DEF = 8;

    localparam logic [3:0] OP_LT    = 4'h0;
    localparam logic [3:0] OP_GT    = 4'h1;
    localparam logic [3:0] OP_INC   = 4'h2;
    localparam logic [3:0] OP_DEC   = 4'h3;
    localparam logic [3:0] OP_OPEN  = 4'h4;
    localparam logic [3:0] OP_CLOSE = 4'h5;
    localparam logic [3:0] OP_OUT   = 4'h6;
    localparam logic [3:0] OP_IN    = 4'h7;
    localparam logic [3:0] OP_STOP  = 4'hF;

    localparam logic [1:0] ERR_NONE            = 2'd0;
    localparam logic [1:0] ERR_UNMATCHED_CLOSE = 2'd1;
    localparam logic [1:0] ERR_UNMATCHED_OPEN  = 2'd2;
    localparam logic [1:0] ERR_OVERFLOW        = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_EVAL,
        ST_WR_OPEN,
        ST_WR_CLOSE,
        ST_FIN,
        ST_ERR
    } jtb_state_e;

endpackage

// File: rtl/bf_bracket_stack.sv
// LIFO of open-bracket addresses; top-of-stack, empty and full are combinational.
module bf_bracket_stack #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] pop_data_c,
    output logic         empty_c,
    output logic         full_c
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign empty_c    = (cnt_q == '0);
    assign full_c     = (cnt_q == CW'(DEPTH));
    assign pop_data_c = mem_q[AW'(cnt_q - CW'(1))];

    // Clear wins over push/pop; push/pop at the limits are dropped.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (push && !full_c) begin
            cnt_d = cnt_q + CW'(1);
        end else if (pop && !empty_c) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full_c && !clr) begin
            mem_q[AW'(cnt_q)] <= push_data;
        end
    end

endmodule

// File: rtl/bf_jump_table_builder.sv
// Single-pass bracket matcher: scans program memory and writes both ends of
// every [ ] pair into the jump-table RAM.
module bf_jump_table_builder
    import bf_pkg::*;
#(
    parameter int unsigned PC_W      = PC_W_DEF,
    parameter int unsigned STK_DEPTH = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic [PC_W-1:0] prog_addr,
    input  logic [3:0]      prog_data,
    output logic            jt_we,
    output logic [PC_W-1:0] jt_addr,
    output logic [PC_W-1:0] jt_data,
    output logic            busy,
    output logic            done,
    output logic            error,
    output logic [1:0]      err_code
);

    localparam logic [PC_W-1:0] PC_LAST = '1;

    jtb_state_e      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] open_q, open_d;
    logic            jt_we_q, jt_we_d;
    logic [PC_W-1:0] jt_addr_q, jt_addr_d;
    logic [PC_W-1:0] jt_data_q, jt_data_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
    logic [1:0]      err_code_q, err_code_d;

    logic            stk_clr, stk_push, stk_pop;
    logic [PC_W-1:0] stk_top;
    logic            stk_empty, stk_full;
    logic            adv, term, term_empty;

    bf_bracket_stack #(
        .DEPTH (STK_DEPTH),
        .W     (PC_W)
    ) u_stack (
        .clk        (clk),
        .reset      (reset),
        .clr        (stk_clr),
        .push       (stk_push),
        .pop        (stk_pop),
        .push_data  (pc_q),
        .pop_data_c (stk_top),
        .empty_c    (stk_empty),
        .full_c     (stk_full)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        open_d     = open_q;
        jt_we_d    = 1'b0;
        jt_addr_d  = jt_addr_q;
        jt_data_d  = jt_data_q;
        err_code_d = err_code_q;
        stk_clr    = 1'b0;
        stk_push   = 1'b0;
        stk_pop    = 1'b0;
        adv        = 1'b0;
        term       = 1'b0;
        term_empty = stk_empty;

        case (state_q)
            ST_IDLE, ST_FIN, ST_ERR: begin
                if (start) begin
                    stk_clr    = 1'b1;
                    pc_d       = '0;
                    err_code_d = ERR_NONE;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_EVAL;
            ST_EVAL: begin
                case (prog_data)
                    OP_OPEN: begin
                        if (stk_full) begin
                            err_code_d = ERR_OVERFLOW;
                            state_d    = ST_ERR;
                        end else begin
                            stk_push   = 1'b1;
                            term_empty = 1'b0;
                            adv        = 1'b1;
                        end
                    end
                    OP_CLOSE: begin
                        if (stk_empty) begin
                            err_code_d = ERR_UNMATCHED_CLOSE;
                            state_d    = ST_ERR;
                        end else begin
                            stk_pop   = 1'b1;
                            open_d    = stk_top;
                            jt_we_d   = 1'b1;
                            jt_addr_d = stk_top;
                            jt_data_d = pc_q;
                            state_d   = ST_WR_OPEN;
                        end
                    end
                    OP_STOP: term = 1'b1;
                    default: adv  = 1'b1;
                endcase
            end
            ST_WR_OPEN: begin
                jt_we_d   = 1'b1;
                jt_addr_d = pc_q;
                jt_data_d = open_q;
                state_d   = ST_WR_CLOSE;
            end
            ST_WR_CLOSE: adv = 1'b1;
            default: state_d = ST_IDLE;
        endcase

        // The last address ends the program exactly like a stop opcode.
        if (adv) begin
            if (pc_q == PC_LAST) begin
                term = 1'b1;
            end else begin
                pc_d    = pc_q + PC_W'(1);
                state_d = ST_ISSUE;
            end
        end
        if (term) begin
            if (term_empty) begin
                state_d = ST_FIN;
            end else begin
                err_code_d = ERR_UNMATCHED_OPEN;
                state_d    = ST_ERR;
            end
        end

        busy_d  = (state_d == ST_ISSUE) || (state_d == ST_EVAL) ||
                  (state_d == ST_WR_OPEN) || (state_d == ST_WR_CLOSE);
        done_d  = (state_d == ST_FIN);
        error_d = (state_d == ST_ERR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            open_q     <= '0;
            jt_we_q    <= 1'b0;
            jt_addr_q  <= '0;
            jt_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            open_q     <= open_d;
            jt_we_q    <= jt_we_d;
            jt_addr_q  <= jt_addr_d;
            jt_data_q  <= jt_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
        end
    end

    assign prog_addr = pc_q;
    assign jt_we     = jt_we_q;
    assign jt_addr   = jt_addr_q;
    assign jt_data   = jt_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_bf_jump_table_builder.sv
// Directed bench for bf_jump_table_builder with a program-level scan model.
module tb_bf_jump_table_builder;

    localparam int unsigned PC_W  = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned NPROG = 256;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [PC_W-1:0] prog_addr;
    logic [3:0]      prog_data;
    logic            jt_we;
    logic [PC_W-1:0] jt_addr;
    logic [PC_W-1:0] jt_data;
    logic            busy;
    logic            done;
    logic            error;
    logic [1:0]      err_code;

    bf_jump_table_builder #(.PC_W(PC_W), .STK_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .jt_we     (jt_we),
        .jt_addr   (jt_addr),
        .jt_data   (jt_data),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    // Synchronous program memory: data one cycle after address.
    logic [3:0] mem [NPROG];
    always @(posedge clk) prog_data <= mem[prog_addr];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model results
    int exp_a[$];
    int exp_d[$];
    int exp_code;
    int exp_cyc;

    // Walk the program as the spec describes, counting 2 cycles per opcode
    // plus 2 for each matched ']'.
    task automatic compute_model();
        int stk[$];
        int o;
        exp_a.delete();
        exp_d.delete();
        exp_cyc  = 0;
        exp_code = -1;
        for (int pc = 0; pc < NPROG; pc++) begin
            exp_cyc += 2;
            if (mem[pc] == 4'h4) begin
                if (stk.size() == DEPTH) begin
                    exp_code = 3;
                    return;
                end
                stk.push_back(pc);
            end else if (mem[pc] == 4'h5) begin
                if (stk.size() == 0) begin
                    exp_code = 1;
                    return;
                end
                o = stk.pop_back();
                exp_a.push_back(o);  exp_d.push_back(pc);
                exp_a.push_back(pc); exp_d.push_back(o);
                exp_cyc += 2;
            end else if (mem[pc] == 4'hF) begin
                exp_code = (stk.size() != 0) ? 2 : 0;
                return;
            end
        end
        exp_code = (stk.size() != 0) ? 2 : 0;
    endtask

    function automatic logic [3:0] enc(input byte c);
        case (c)
            "<": return 4'h0;
            ">": return 4'h1;
            "+": return 4'h2;
            "-": return 4'h3;
            "[": return 4'h4;
            "]": return 4'h5;
            ".": return 4'h6;
            ",": return 4'h7;
            "F": return 4'hF;
            default: return 4'h8;
        endcase
    endfunction

    task automatic load(input string s, input logic [3:0] fill);
        for (int i = 0; i < NPROG; i++) mem[i] = fill;
        for (int i = 0; i < s.len(); i++) mem[i] = enc(s[i]);
    endtask

    // Per-cycle compare process
    bit chk_en = 1'b0;
    int busy_cnt;
    int obs_a[$];
    int obs_d[$];

    always @(negedge clk) begin
        if (chk_en) begin
            if (busy) begin
                busy_cnt++;
                chk("flags_while_busy", {30'd0, done, error}, 0);
            end else begin
                chk("jt_we_not_busy", {31'd0, jt_we}, 0);
            end
            if (jt_we) begin
                obs_a.push_back(int'(jt_addr));
                obs_d.push_back(int'(jt_data));
                chk("jt_write_expected", exp_a.size() > 0, 1);
                if (exp_a.size() > 0) begin
                    chk("jt_addr", {24'd0, jt_addr}, exp_a.pop_front());
                    chk("jt_data", {24'd0, jt_data}, exp_d.pop_front());
                end
            end
        end
    end

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic run(input string name, input bit poke_start);
        int lat;
        compute_model();
        busy_cnt = 0;
        obs_a.delete();
        obs_d.delete();
        chk_en = 1'b1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk({name, "_busy_rise"}, {31'd0, busy}, 1);
        chk({name, "_flags_clear"}, {29'd0, done, error, err_code}, 0);
        lat = 1;
        while (!(done || error) && lat < 3000) begin
            @(negedge clk);
            lat++;
            start = poke_start && (lat == 5);
        end
        start = 1'b0;
        chk({name, "_latency"}, lat, exp_cyc + 1);
        chk({name, "_busy_cycles"}, busy_cnt, exp_cyc);
        chk({name, "_done"}, {31'd0, done}, (exp_code == 0) ? 1 : 0);
        chk({name, "_error"}, {31'd0, error}, (exp_code != 0) ? 1 : 0);
        chk({name, "_err_code"}, {30'd0, err_code}, exp_code);
        chk({name, "_writes_left"}, exp_a.size(), 0);
        repeat (3) @(negedge clk);
        chk({name, "_flags_held"}, {29'd0, done, error, err_code},
            (exp_code == 0) ? 32'd8 : (32'd4 | 32'(exp_code)));
        chk_en = 1'b0;
    endtask

    initial begin
        int n;
        int we_seen;
        reset = 1'b1;
        start = 1'b0;
        load("", 4'hF);
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {busy, done, error, jt_we, err_code, 26'd0}, 0);
        chk("reset_addrs", {prog_addr, jt_addr, jt_data, 8'd0}, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 0);

        load("+[->+<]F", 4'hF);
        run("simple_loop", 1'b0);
        chk("simple_busy_18", busy_cnt, 18);
        chk("simple_w0", {qget(obs_a, 0), qget(obs_d, 0)}, {1, 6});
        chk("simple_w1", {qget(obs_a, 1), qget(obs_d, 1)}, {6, 1});

        load("[[]]F", 4'hF);
        run("nested", 1'b1);
        chk("nested_nwr", obs_a.size(), 4);
        chk("nested_w0", {qget(obs_a, 0), qget(obs_d, 0)}, {1, 2});
        chk("nested_w1", {qget(obs_a, 1), qget(obs_d, 1)}, {2, 1});
        chk("nested_w2", {qget(obs_a, 2), qget(obs_d, 2)}, {0, 3});
        chk("nested_w3", {qget(obs_a, 3), qget(obs_d, 3)}, {3, 0});

        load("]F", 4'hF);
        run("unmatched_close", 1'b0);
        chk("uclose_code_1", {30'd0, err_code}, 1);
        chk("uclose_no_we", obs_a.size(), 0);

        load("[[F", 4'hF);
        run("unmatched_open", 1'b0);
        chk("uopen_code_2", {30'd0, err_code}, 2);

        load("", 4'hF);
        for (int i = 0; i < 17; i++) mem[i] = 4'h4;
        run("overflow", 1'b0);
        chk("ovf_code_3", {30'd0, err_code}, 3);
        chk("ovf_busy_34", busy_cnt, 34);

        load("", 4'h2);
        run("no_stop", 1'b0);
        chk("nostop_busy_512", busy_cnt, 512);
        chk("nostop_done", {31'd0, done}, 1);

        load("x[.x,]xF", 4'hF);
        run("ignored_ops", 1'b0);
        chk("ign_w0", {qget(obs_a, 0), qget(obs_d, 0)}, {1, 5});

        // Reset while the first write of a pair is on the port.
        load("+[->+<]F", 4'hF);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while (!jt_we && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rst_found_wr_open", {31'd0, jt_we}, 1);
        chk("rst_wr_open_addr", {24'd0, jt_addr}, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_outputs", {29'd0, busy, jt_we, done}, 0);
        reset = 1'b0;
        we_seen = 0;
        repeat (4) begin
            @(negedge clk);
            we_seen += int'(jt_we) + int'(busy);
        end
        chk("rst_quiet_after", we_seen, 0);
        run("rescan", 1'b0);
        chk("rescan_nwr", obs_a.size(), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
